obstacle_frame_scheduler: RTL and testbench
===========================================

# obstacle_frame_scheduler

Per-frame sequencer for the player/obstacle game-logic block. On each frame strobe it walks the obstacle table RAM and streams every entry to game logic with `obstacle_valid`/`firstrow`. Only after the last entry has been delivered does it issue the single-cycle `new_frame` tick, so game logic always sees a complete, ordered obstacle sweep before advancing. It also owns the game-over / restart lifecycle and generates the game-logic reset.

## Interface
Parameters:
- `NUM_OBSTACLES`, 16: obstacle table entries scanned per frame; must be ≥ 2.
- `FIRSTROW_MAX`, 319: largest `obstacle[10:0]` depth flagged as first row.
- `RESTART_HOLD`, 4: cycles `game_rst` is held high during restart; must be ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  single-cycle frame strobe from video timing.
- `pause`  in  1  level; suppresses the `new_frame` tick.
- `restart`  in  1  single-cycle restart request.
- `game_over`  in  1  level from game logic.
- `rd_en`  out  1  table read strobe.
- `rd_addr`  out  $clog2(NUM_OBSTACLES)  table read address.
- `rd_data`  in  16  table data, valid exactly one cycle after `rd_en`.
- `obstacle`  out  16  forwarded entry: {type[15:13], lane[12:11], depth[10:0]}.
- `obstacle_valid`  out  1  `obstacle` qualifier.
- `firstrow`  out  1  entry intersects the player's row.
- `new_frame`  out  1  single-cycle game-advance tick.
- `game_rst`  out  1  reset to game logic.
- `busy`  out  1  high while a frame sequence is in flight.
- `overrun`  out  1  sticky: a `frame_start` arrived while busy.
- `frame_count`  out  16  number of `new_frame` ticks issued.

## Operation
- **States:** IDLE, SCAN, DRAIN (2 cycles), TICK, OVER, RESTART.
- **IDLE:**
  - `restart` → RESTART.
  - else `game_over` → OVER.
  - else `frame_start` → SCAN with `idx`=0.
- **SCAN:** `rd_en`=1 and `rd_addr`=`idx` (combinational from state/`idx`). `idx` increments each cycle. After issuing `idx`=`NUM_OBSTACLES`-1 → DRAIN.
- **Forwarding register** (every cycle):
  - `obstacle` <= `rd_data`.
  - `obstacle_valid` <= `rd_en` delayed one cycle.
  - `firstrow` <= that same delayed `rd_en` && `rd_data[15:13]`!=0 && `rd_data[10:0]` <= `FIRSTROW_MAX`.
  - Type-000 (empty) entries are still forwarded with `obstacle_valid`=1 and `firstrow`=0.
- **DRAIN:** two cycles, delivering the final entry. Then → TICK.
- **TICK** (one cycle):
  - If `game_over`: no pulse → OVER.
  - Else if `pause`: no pulse → IDLE.
  - Else: `new_frame`=1, `frame_count`+1 (wraps at 2^16) → IDLE.
- **OVER:** no scans; `frame_start` is ignored and does not set `overrun`. `restart` → RESTART.
- **RESTART:**
  - `game_rst`=1 for `RESTART_HOLD` cycles.
  - `frame_count` cleared, `overrun` cleared, `idx` cleared.
  - `obstacle_valid`/`firstrow` forced 0 from the next cycle.
  - Then → IDLE.
- `restart` is accepted in any state, including mid-SCAN: the scan is aborted and no `new_frame` is issued for that frame.
- Simultaneous `restart` and `frame_start`: restart wins; the frame is dropped.
- `busy` = state ∈ {SCAN, DRAIN, TICK}. A `frame_start` while busy sets `overrun` and is otherwise ignored; the in-flight sequence completes normally.
- `rst` mid-operation: abort immediately; all outputs return to reset values on the next cycle.

## Timing
- Reset values: state IDLE, `idx`=0, `rd_en`=0, `rd_addr`=0, `obstacle`=0, `obstacle_valid`=0, `firstrow`=0, `new_frame`=0, `game_rst`=1 (asserted while `rst` is high), `busy`=0, `overrun`=0, `frame_count`=0.
- With `frame_start` sampled in IDLE at cycle t, where N = `NUM_OBSTACLES`:
  - `rd_en` high t+1..t+N, with `rd_addr` 0..N-1 in order.
  - `obstacle_valid` high t+3..t+N+2.
  - `new_frame` at t+N+3.
  - `busy` high t+1..t+N+3.
- Next `frame_start` is accepted at t+N+4 or later. For N=16: tick at t+19, re-accept at t+20.
- `new_frame` is never high in the same cycle as `obstacle_valid`. Every entry of a frame precedes that frame's tick, because game logic reloads its ground level on `new_frame`.
- `game_over` is sampled only in IDLE and TICK.

## Test plan
- **Nominal frame:** N=16, table entry i = {3'b100, 2'd1, 11'(i*20)}; pulse `frame_start` at cycle 0 → 16 valid entries at cycles 3..18 in address order; `firstrow`=1 for i ≤ 15 (depth ≤ 300, since 15*20=300 ≤ 319); `new_frame` only at cycle 19; `frame_count`=1.
- **Overrun:** second `frame_start` at cycle 5 → `overrun`=1, still exactly one `new_frame` at cycle 19; `frame_start` at cycle 20 → new scan, `new_frame` at 39.
- **Pause:** `pause`=1 through a frame → full scan occurs, no `new_frame`, `frame_count` unchanged; `busy` drops at cycle 20.
- **Game over:** assert `game_over` before cycle 19 → no tick, state OVER; later `frame_start` strobes produce no `rd_en` and leave `overrun`=0.
- **Restart mid-scan:** `restart` at cycle 8 → `rd_en` low from cycle 9, `obstacle_valid` low from cycle 9, `game_rst` high cycles 9..12, `frame_count`=0, no `new_frame`; next `frame_start` scans normally.
- **Firstrow boundary:** entry depths 319 and 320 with type 101 → `firstrow` 1 then 0; type 000 at depth 0 → `obstacle_valid`=1, `firstrow`=0.

Source files
------------

// File: rtl/obstacle_frame_scheduler.sv
// Per-frame obstacle table sweep: streams every entry to game logic, then issues new_frame.
// Also owns the game-over / restart lifecycle and the game-logic reset.
module obstacle_frame_scheduler #(
  parameter int unsigned NUM_OBSTACLES = 16,
  parameter int unsigned FIRSTROW_MAX  = 319,
  parameter int unsigned RESTART_HOLD  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic                             pause,
  input  logic                             restart,
  input  logic                             game_over,
  output logic                             rd_en,
  output logic [$clog2(NUM_OBSTACLES)-1:0] rd_addr,
  input  logic [15:0]                      rd_data,
  output logic [15:0]                      obstacle,
  output logic                             obstacle_valid,
  output logic                             firstrow,
  output logic                             new_frame,
  output logic                             game_rst,
  output logic                             busy,
  output logic                             overrun,
  output logic [15:0]                      frame_count
);

  localparam int unsigned AW = $clog2(NUM_OBSTACLES);
  localparam int unsigned HW = $clog2(RESTART_HOLD + 1);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StDrain,
    StTick,
    StOver,
    StRestart
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          drain_q, drain_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          overrun_q, overrun_d;
  logic          rd_en_q;
  logic [15:0]   obstacle_q;
  logic          valid_q, firstrow_q;
  logic          fwd_en;

  assign rd_en          = (state_q == StScan);
  assign rd_addr        = rd_en ? idx_q : '0;
  assign busy           = (state_q == StScan) || (state_q == StDrain) || (state_q == StTick);
  assign game_rst       = rst || (state_q == StRestart);
  assign obstacle       = obstacle_q;
  assign obstacle_valid = valid_q;
  assign firstrow       = firstrow_q;
  assign overrun        = overrun_q;
  assign frame_count    = frame_count_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    drain_d       = drain_q;
    hold_d        = hold_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    new_frame     = 1'b0;

    if (busy && frame_start) begin
      overrun_d = 1'b1;
    end

    // Restart pre-empts everything, including a simultaneous frame_start or tick.
    if (restart) begin
      state_d       = StRestart;
      hold_d        = '0;
      idx_d         = '0;
      frame_count_d = '0;
      overrun_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (game_over) begin
            state_d = StOver;
          end else if (frame_start) begin
            state_d = StScan;
            idx_d   = '0;
          end
        end
        StScan: begin
          if (idx_q == AW'(NUM_OBSTACLES - 1)) begin
            state_d = StDrain;
            idx_d   = '0;
            drain_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        StDrain: begin
          if (drain_q) begin
            state_d = StTick;
          end else begin
            drain_d = 1'b1;
          end
        end
        StTick: begin
          if (game_over) begin
            state_d = StOver;
          end else if (pause) begin
            state_d = StIdle;
          end else begin
            new_frame     = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = StIdle;
          end
        end
        StOver: begin
        end
        StRestart: begin
          frame_count_d = '0;
          overrun_d     = 1'b0;
          if (hold_q == HW'(RESTART_HOLD - 1)) begin
            state_d = StIdle;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Forwarding is squashed the cycle a restart is sampled and throughout the hold.
  assign fwd_en = rd_en_q && !restart && (state_q != StRestart);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      drain_q       <= 1'b0;
      hold_q        <= '0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      rd_en_q       <= 1'b0;
      obstacle_q    <= '0;
      valid_q       <= 1'b0;
      firstrow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      drain_q       <= drain_d;
      hold_q        <= hold_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      rd_en_q       <= rd_en;
      obstacle_q    <= rd_data;
      valid_q       <= fwd_en;
      firstrow_q    <= fwd_en && (rd_data[15:13] != 3'b000) &&
                       ({21'd0, rd_data[10:0]} <= FIRSTROW_MAX);
    end
  end

endmodule

// File: tb/tb_obstacle_frame_scheduler.sv
// Bench for obstacle_frame_scheduler: a frame-offset timeline model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_obstacle_frame_scheduler;

  localparam int N    = 16;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        pause = 1'b0;
  logic        restart = 1'b0;
  logic        game_over = 1'b0;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] obstacle;
  logic        obstacle_valid;
  logic        firstrow;
  logic        new_frame;
  logic        game_rst;
  logic        busy;
  logic        overrun;
  logic [15:0] frame_count;

  logic [15:0] tbl [N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: 0 idle, 1 frame in flight, 2 game over, 3 restart hold.
  int m_mode = 0;
  int m_t0 = -100;
  int m_rleft = 0;
  int m_fc = 0;
  int m_ovr = 0;

  obstacle_frame_scheduler #(
    .NUM_OBSTACLES(N),
    .FIRSTROW_MAX (319),
    .RESTART_HOLD (HOLD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .pause         (pause),
    .restart       (restart),
    .game_over     (game_over),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .obstacle      (obstacle),
    .obstacle_valid(obstacle_valid),
    .firstrow      (firstrow),
    .new_frame     (new_frame),
    .game_rst      (game_rst),
    .busy          (busy),
    .overrun       (overrun),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  // Table RAM: one-cycle read latency; junk that looks like a first-row hit when idle.
  always @(posedge clk) rd_data <= rd_en ? tbl[rd_addr] : 16'hC0AD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_first(input logic [15:0] e);
    return (e[15:13] != 3'b000) && (e[10:0] <= 11'd319);
  endfunction

  // Model advance: inputs seen at this edge belong to the cycle that just ended.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_mode = 0; m_fc = 0; m_ovr = 0;
      end else if (restart) begin
        m_mode = 3; m_rleft = HOLD; m_fc = 0; m_ovr = 0;
      end else begin
        case (m_mode)
          0: begin
            if (game_over) m_mode = 2;
            else if (frame_start) begin m_mode = 1; m_t0 = cyc; end
          end
          1: begin
            if (frame_start) m_ovr = 1;
            if (cyc - m_t0 == N + 3) begin
              if (game_over) m_mode = 2;
              else if (pause) m_mode = 0;
              else begin m_fc = (m_fc + 1) % 65536; m_mode = 0; end
            end
          end
          3: begin
            m_rleft = m_rleft - 1;
            if (m_rleft == 0) m_mode = 0;
          end
          default: ;
        endcase
      end
      cyc = cyc + 1;
    end
  end

  // Per-cycle compare against the frame-offset timeline.
  initial begin
    int k;
    bit e_rd, e_v;
    forever begin
      @(negedge clk);
      #2;
      if (cyc >= 1) begin
        chk("game_rst", game_rst, (rst || m_mode == 3));
        if (!rst) begin
          k    = cyc - m_t0;
          e_rd = (m_mode == 1) && k >= 1 && k <= N;
          e_v  = (m_mode == 1) && k >= 3 && k <= N + 2;
          chk("rd_en", rd_en, e_rd);
          if (e_rd) chk("rd_addr", rd_addr, k - 1);
          chk("obstacle_valid", obstacle_valid, e_v);
          if (e_v) begin
            chk("obstacle", obstacle, tbl[k-3]);
            chk("firstrow", firstrow, is_first(tbl[k-3]));
          end else begin
            chk("firstrow", firstrow, 0);
          end
          chk("new_frame", new_frame,
              (m_mode == 1) && k == N + 3 && !game_over && !pause && !restart);
          chk("busy", busy, m_mode == 1);
          chk("overrun", overrun, m_ovr);
          chk("frame_count", frame_count, m_fc);
        end
      end
    end
  end

  task automatic at_cyc(input int c);
    forever begin
      @(negedge clk);
      if (cyc >= c) break;
    end
  endtask

  task automatic probe(input int c);
    at_cyc(c);
    #2;
  endtask

  initial begin
    int t;
    for (int i = 0; i < N; i++) tbl[i] = {3'b100, 2'd1, 11'(i * 20)};

    probe(1);
    chk("lit_game_rst_in_reset", game_rst, 1);
    at_cyc(3);
    rst = 1'b0;
    #2;
    chk("lit_reset_obstacle", obstacle, 0);
    chk("lit_reset_busy", busy, 0);
    chk("lit_reset_rd_en", rd_en, 0);
    chk("lit_reset_game_rst", game_rst, 0);
    chk("lit_reset_frame_count", frame_count, 0);

    // Nominal frame.
    t = 5;
    at_cyc(t); frame_start = 1'b1;
    at_cyc(t + 1); frame_start = 1'b0;
    #2; chk("lit_nom_rd_en", rd_en, 1); chk("lit_nom_addr0", rd_addr, 0);
    probe(t + 3); chk("lit_nom_first_valid", obstacle_valid, 1);
    chk("lit_nom_entry0", obstacle, 16'h8800);
    probe(t + 8); chk("lit_nom_entry5", obstacle, 16'h8864);
    probe(t + 18); chk("lit_nom_entry15", obstacle, 16'h892C);
    chk("lit_nom_firstrow15", firstrow, 1);
    probe(t + 19); chk("lit_nom_tick", new_frame, 1); chk("lit_nom_tick_novalid", obstacle_valid, 0);
    probe(t + 20); chk("lit_nom_count", frame_count, 1); chk("lit_nom_idle", busy, 0);

    // Overrun, then back-to-back re-accept.
    t = 30;
    at_cyc(t); frame_start = 1'b1;
    at_cyc(t + 1); frame_start = 1'b0;
    at_cyc(t + 5); frame_start = 1'b1;
    at_cyc(t + 6); frame_start = 1'b0;
    #2; chk("lit_ovr_set", overrun, 1);
    probe(t + 19); chk("lit_ovr_tick", new_frame, 1);
    at_cyc(t + 20); frame_start = 1'b1;
    at_cyc(t + 21); frame_start = 1'b0;
    #2; chk("lit_reaccept_rd_en", rd_en, 1);
    probe(t + 39); chk("lit_reaccept_tick", new_frame, 1);
    probe(t + 40); chk("lit_reaccept_count", frame_count, 3);

    // Pause through a whole frame.
    t = 80;
    at_cyc(t); pause = 1'b1; frame_start = 1'b1;
    at_cyc(t + 1); frame_start = 1'b0;
    probe(t + 19); chk("lit_pause_no_tick", new_frame, 0); chk("lit_pause_busy", busy, 1);
    probe(t + 20); chk("lit_pause_busy_drop", busy, 0); chk("lit_pause_count", frame_count, 3);
    at_cyc(t + 21); pause = 1'b0;

    // Restart mid-scan.
    t = 110;
    at_cyc(t); frame_start = 1'b1;
    at_cyc(t + 1); frame_start = 1'b0;
    at_cyc(t + 8); restart = 1'b1;
    at_cyc(t + 9); restart = 1'b0;
    #2; chk("lit_rs_rd_en", rd_en, 0); chk("lit_rs_valid", obstacle_valid, 0);
    chk("lit_rs_game_rst", game_rst, 1); chk("lit_rs_count", frame_count, 0);
    chk("lit_rs_overrun", overrun, 0);
    probe(t + 12); chk("lit_rs_hold_end", game_rst, 1);
    probe(t + 13); chk("lit_rs_released", game_rst, 0);
    at_cyc(t + 14); frame_start = 1'b1;
    at_cyc(t + 15); frame_start = 1'b0;
    probe(t + 33); chk("lit_rs_next_tick", new_frame, 1);
    probe(t + 34); chk("lit_rs_next_count", frame_count, 1);

    // First-row boundary and empty entries.
    t = 160;
    at_cyc(t - 2);
    tbl[0] = 16'hA13F;
    tbl[1] = 16'hA140;
    tbl[2] = 16'h0000;
    at_cyc(t); frame_start = 1'b1;
    at_cyc(t + 1); frame_start = 1'b0;
    probe(t + 3); chk("lit_fr_319", firstrow, 1); chk("lit_fr_319_obs", obstacle, 16'hA13F);
    probe(t + 4); chk("lit_fr_320", firstrow, 0); chk("lit_fr_320_valid", obstacle_valid, 1);
    probe(t + 5); chk("lit_fr_empty_valid", obstacle_valid, 1); chk("lit_fr_empty", firstrow, 0);
    probe(t + 19); chk("lit_fr_tick", new_frame, 1);

    // Simultaneous restart and frame_start: restart wins.
    t = 185;
    at_cyc(t); frame_start = 1'b1; restart = 1'b1;
    at_cyc(t + 1); frame_start = 1'b0; restart = 1'b0;
    #2; chk("lit_sim_no_scan", rd_en, 0); chk("lit_sim_game_rst", game_rst, 1);

    // Game over before the tick.
    t = 195;
    at_cyc(t); frame_start = 1'b1;
    at_cyc(t + 1); frame_start = 1'b0;
    at_cyc(t + 10); game_over = 1'b1;
    probe(t + 19); chk("lit_go_no_tick", new_frame, 0);
    probe(t + 20); chk("lit_go_not_busy", busy, 0);
    at_cyc(t + 25); frame_start = 1'b1;
    at_cyc(t + 26); frame_start = 1'b0;
    #2; chk("lit_go_no_scan", rd_en, 0); chk("lit_go_no_overrun", overrun, 0);
    at_cyc(t + 30); restart = 1'b1; game_over = 1'b0;
    at_cyc(t + 31); restart = 1'b0;
    probe(t + 36); chk("lit_go_recovered", game_rst, 0); chk("lit_go_idle", busy, 0);
    at_cyc(t + 37); frame_start = 1'b1;
    at_cyc(t + 38); frame_start = 1'b0;
    #2; chk("lit_go_rescan", rd_en, 1);
    probe(t + 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
